// File: rtl/sw_word_packer.sv
// Packs a column of signed (V,F) score pairs into fixed-width SRAM words, with an
// entry-count header per word; one write cycle per full or final word.
module sw_word_packer #(
    parameter int unsigned VEF_BIT    = 18,
    parameter int unsigned T_PER_WORD = 7,
    parameter int unsigned HEADER_BIT = 4,
    parameter int unsigned WORD_W     = 256,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VEF_BIT-1:0]   in_v,
    input  logic [VEF_BIT-1:0]   in_f,
    input  logic                 in_last,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [WORD_W-1:0]    sram_d,
    output logic                 done,
    output logic [ADDR_W:0]      words_written,
    output logic                 overflow
);

    localparam int unsigned ENTRY_W   = 2 * VEF_BIT;
    localparam int unsigned PAYLOAD_W = T_PER_WORD * ENTRY_W;
    localparam int unsigned SLOT_W    = (T_PER_WORD > 1) ? $clog2(T_PER_WORD) : 1;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [PAYLOAD_W-1:0]   buf_q, buf_d;
    logic                   last_q, last_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   wrapped_q, wrapped_d;
    logic [CNT_W-1:0]       words_q, words_d;
    logic                   overflow_q, overflow_d;
    logic                   cen_q, cen_d;
    logic                   wen_q, wen_d;
    logic [ADDR_W-1:0]      sram_addr_q, sram_addr_d;
    logic [WORD_W-1:0]      sram_d_q, sram_d_d;

    logic [PAYLOAD_W-1:0]   entry_buf;
    logic [WORD_W-1:0]      word;

    // Buffer with the incoming entry merged at the current slot, and the full word it forms.
    always_comb begin
        entry_buf = buf_q;
        entry_buf[int'(slot_q) * ENTRY_W +: ENTRY_W] = {in_v, in_f};
        word = '0;
        word[PAYLOAD_W-1:0] = entry_buf;
        word[WORD_W-1 -: HEADER_BIT] = HEADER_BIT'(slot_q) + HEADER_BIT'(1);
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        buf_d       = buf_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wrapped_d   = wrapped_q;
        words_d     = words_q;
        overflow_d  = overflow_q;
        cen_d       = 1'b1;
        wen_d       = 1'b1;
        sram_addr_d = sram_addr_q;
        sram_d_d    = sram_d_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = base_addr;
                    slot_d     = '0;
                    buf_d      = '0;
                    last_d     = 1'b0;
                    words_d    = '0;
                    overflow_d = 1'b0;
                    wrapped_d  = 1'b0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (in_valid) begin
                    buf_d = entry_buf;
                    if (slot_q == SLOT_W'(T_PER_WORD - 1) || in_last) begin
                        state_d = StWrite;
                        last_d  = in_last;
                        // Past the top of the address space: drop the strobe, keep the flow.
                        if (wrapped_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            cen_d       = 1'b0;
                            wen_d       = 1'b0;
                            sram_addr_d = addr_q;
                            sram_d_d    = word;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            StWrite: begin
                buf_d  = '0;
                slot_d = '0;
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    wrapped_d = 1'b1;
                end
                if (!wrapped_q) begin
                    words_d = words_q + CNT_W'(1);
                end
                state_d = last_q ? StDone : StFill;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            buf_q       <= '0;
            last_q      <= 1'b0;
            addr_q      <= '0;
            wrapped_q   <= 1'b0;
            words_q     <= '0;
            overflow_q  <= 1'b0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            sram_addr_q <= '0;
            sram_d_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            buf_q       <= buf_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wrapped_q   <= wrapped_d;
            words_q     <= words_d;
            overflow_q  <= overflow_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            sram_addr_q <= sram_addr_d;
            sram_d_q    <= sram_d_d;
        end
    end

    assign in_ready      = (state_q == StFill);
    assign done          = (state_q == StDone);
    assign sram_cen      = cen_q;
    assign sram_wen      = wen_q;
    assign sram_addr     = sram_addr_q;
    assign sram_d        = sram_d_q;
    assign words_written = words_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_sw_word_packer.sv
// Directed bench for sw_word_packer: single/multi-word columns, stalls, overflow,
// mid-column reset and ignored start.
module tb_sw_word_packer;

    localparam int unsigned VEF_BIT = 18;
    localparam int unsigned WORD_W  = 256;
    localparam int unsigned ADDR_W  = 10;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic                in_valid;
    logic                in_ready;
    logic [VEF_BIT-1:0]  in_v;
    logic [VEF_BIT-1:0]  in_f;
    logic                in_last;
    logic                sram_cen;
    logic                sram_wen;
    logic [ADDR_W-1:0]   sram_addr;
    logic [WORD_W-1:0]   sram_d;
    logic                done;
    logic [ADDR_W:0]     words_written;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;
    int stall_nowrite;

    logic [ADDR_W-1:0]  wr_addr[$];
    logic [WORD_W-1:0]  wr_data[$];
    logic [VEF_BIT-1:0] sent_v[$];
    logic [VEF_BIT-1:0] sent_f[$];

    sw_word_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_v          (in_v),
        .in_f          (in_f),
        .in_last       (in_last),
        .sram_cen      (sram_cen),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_d        (sram_d),
        .done          (done),
        .words_written (words_written),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // SRAM write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && !sram_cen && !sram_wen) begin
            wr_addr.push_back(sram_addr);
            wr_data.push_back(sram_d);
        end
    end

    function automatic logic [WORD_W-1:0] pack_word(int first, int n);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[36*k+18 +: 18] = sent_v[first+k];
            w[36*k +: 18]    = sent_f[first+k];
        end
        w[255:252] = 4'(n);
        return w;
    endfunction

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        sent_v.delete();
        sent_f.delete();
        stalls = 0;
        stall_nowrite = 0;
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic do_start(input logic [ADDR_W-1:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [VEF_BIT-1:0] v, input logic [VEF_BIT-1:0] f,
                        input logic last, input int gap);
        int w;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_v = v;
        in_f = f;
        in_last = last;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            stalls++;
            if (sram_cen) stall_nowrite++;
            w++;
            @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        sent_v.push_back(v);
        sent_f.push_back(f);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        @(negedge clk);
        while (!done && w < 20) begin
            w++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b required 0", done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b1 || sram_wen !== 1'b1 ||
            sram_addr !== '0 || sram_d !== '0 || done !== 1'b0 ||
            words_written !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b cen=%b wen=%b addr=%0d d=%h done=%b ww=%0d ovf=%b required 0 1 1 0 0 0 0 0",
                     tag, in_ready, sram_cen, sram_wen, sram_addr, sram_d, done,
                     words_written, overflow);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        clear_logs();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || sram_cen !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_ignore: rdy=%b cen=%b required 0 1", in_ready, sram_cen);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_write: writes=%0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_basic();
        clear_logs();
        do_start(10'd5);
        for (int k = 0; k < 7; k++)
            send(18'(k + 1), 18'(-(k + 1)), k == 6, 0);
        // Strobe is live in the cycle right after the completing entry.
        n_checks++;
        if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL basic_strobe: cen=%b wen=%b addr=%0d required 0 0 5",
                     sram_cen, sram_wen, sram_addr);
        end
        n_checks++;
        if (sram_d !== pack_word(0, 7)) begin
            n_fail++;
            $display("FAIL basic_data: got %h required %h", sram_d, pack_word(0, 7));
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_write: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || words_written !== 11'd1 || sram_cen !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: done=%b ww=%0d cen=%b required 1 1 1",
                     done, words_written, sram_cen);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || wr_addr.size() != 1) begin
            n_fail++;
            $display("FAIL basic_after: done=%b writes=%0d required 0 1", done, wr_addr.size());
        end
    endtask

    task automatic test_stream10();
        clear_logs();
        do_start(10'd40);
        for (int i = 0; i < 10; i++)
            send(18'(1000 + i), 18'(-(3 * i + 1)), i == 9, 0);
        wait_done();
        n_checks++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL s10_count: writes=%0d required 2", wr_addr.size());
        end else begin
            n_checks++;
            if (wr_addr[0] !== 10'd40 || wr_addr[1] !== 10'd41) begin
                n_fail++;
                $display("FAIL s10_addr: got %0d %0d required 40 41", wr_addr[0], wr_addr[1]);
            end
            n_checks++;
            if (wr_data[0] !== pack_word(0, 7)) begin
                n_fail++;
                $display("FAIL s10_word0: got %h required %h", wr_data[0], pack_word(0, 7));
            end
            n_checks++;
            if (wr_data[1] !== pack_word(7, 3) || wr_data[1][251:108] !== '0) begin
                n_fail++;
                $display("FAIL s10_word1: got %h required %h", wr_data[1], pack_word(7, 3));
            end
        end
        n_checks++;
        if (stalls != 1 || stall_nowrite != 0) begin
            n_fail++;
            $display("FAIL s10_stalls: stalls=%0d non_write_stalls=%0d required 1 0",
                     stalls, stall_nowrite);
        end
        n_checks++;
        if (words_written !== 11'd2) begin
            n_fail++;
            $display("FAIL s10_words: ww=%0d required 2", words_written);
        end
    endtask

    task automatic test_random_valid();
        clear_logs();
        do_start(10'd100);
        for (int i = 0; i < 21; i++)
            send(18'(5 * i + 7), 18'(-(11 * i + 2)), i == 20, int'($urandom_range(0, 2)));
        wait_done();
        n_checks++;
        if (wr_addr.size() != 3) begin
            n_fail++;
            $display("FAIL rnd_count: writes=%0d required 3", wr_addr.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (wr_addr[j] !== 10'(100 + j) || wr_data[j] !== pack_word(7 * j, 7)) begin
                    n_fail++;
                    $display("FAIL rnd_word%0d: addr=%0d data=%h required %0d %h", j,
                             wr_addr[j], wr_data[j], 100 + j, pack_word(7 * j, 7));
                end
            end
        end
        n_checks++;
        if (words_written !== 11'd3) begin
            n_fail++;
            $display("FAIL rnd_words: ww=%0d required 3", words_written);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        do_start(10'd1023);
        for (int i = 0; i < 14; i++) begin
            send(18'(i + 50), 18'(-(i + 60)), i == 13, 0);
            if (i == 6) begin
                n_checks++;
                if (overflow !== 1'b0 || sram_cen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_first: ovf=%b cen=%b required 0 0", overflow, sram_cen);
                end
            end
        end
        n_checks++;
        if (sram_cen !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_suppress: cen=%b ovf=%b required 1 1", sram_cen, overflow);
        end
        wait_done();
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd1023 || wr_data[0] !== pack_word(0, 7)) begin
            n_fail++;
            $display("FAIL ovf_writes: writes=%0d required one word at 1023", wr_addr.size());
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b required 1", overflow);
        end
    endtask

    task automatic test_midreset();
        clear_logs();
        do_start(10'd7);
        for (int i = 0; i < 4; i++)
            send(18'(i + 3), 18'(i + 9), 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_values");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_write: writes=%0d required 0", wr_addr.size());
        end
        check_reset_outputs("midreset_idle");
        test_basic();
    endtask

    task automatic test_start_in_fill();
        clear_logs();
        do_start(10'd20);
        for (int i = 0; i < 3; i++)
            send(18'(i + 200), 18'(-(i + 300)), 1'b0, 0);
        do_start(10'd99);
        for (int i = 3; i < 7; i++)
            send(18'(i + 200), 18'(-(i + 300)), i == 6, 0);
        wait_done();
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd20 || wr_data[0] !== pack_word(0, 7)) begin
            n_fail++;
            $display("FAIL start_ignored: writes=%0d required one word at 20", wr_addr.size());
        end
        n_checks++;
        if (words_written !== 11'd1) begin
            n_fail++;
            $display("FAIL start_ignored_words: ww=%0d required 1", words_written);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_v = '0;
        in_f = '0;
        in_last = 1'b0;
        test_reset();
        test_basic();
        test_stream10();
        test_random_valid();
        test_overflow();
        test_midreset();
        test_start_in_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
